// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and downstream memory signals that meet at
// the memory arbiter. The arbiter takes the slave view; whatever drives the
// caches and models the memory takes the master view.
interface mem_arbiter_if;
  // icache line-fill port
  logic         icache_read;
  logic [15:0]  icache_address;
  logic [127:0] icache_rdata;
  logic         icache_resp;

  // dcache read/write port
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic [127:0] dcache_rdata;
  logic         dcache_resp;

  // downstream memory port
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;

  // arbiter status
  logic         busy;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    output busy
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. The icache (line fills) and the dcache
// (reads and writes) share one downstream memory port. The dcache wins
// simultaneous requests, but only STARVE_LIMIT times in a row while the
// icache is waiting; after that the icache is guaranteed the next grant.
// Every output is a register; the memory request is built only from values
// latched at grant time, so requesters may change their inputs freely while
// a transaction is in flight.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  // Counter is at least three bits and always wide enough to hold the limit.
  localparam int CLOG_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W  = (CLOG_W > 3) ? CLOG_W : 3;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t         state_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [15:0]    addr_r;
  logic [127:0]   wdata_r;
  logic           mem_read_r;
  logic           mem_write_r;
  logic [127:0]   icache_rdata_r;
  logic [127:0]   dcache_rdata_r;
  logic           icache_resp_r;
  logic           dcache_resp_r;
  logic           busy_r;

  logic           ipend_s;
  logic           dpend_s;
  logic           dgrant_s;

  assign ipend_s  = bus.icache_read;
  assign dpend_s  = bus.dcache_read | bus.dcache_write;
  // dcache wins unless the icache is waiting and has already been passed
  // over STARVE_LIMIT times.
  assign dgrant_s = dpend_s & (~ipend_s | (starve_cnt_r < LIMIT_C));

  assign bus.mem_read     = mem_read_r;
  assign bus.mem_write    = mem_write_r;
  assign bus.mem_address  = addr_r;
  assign bus.mem_wdata    = wdata_r;
  assign bus.icache_rdata = icache_rdata_r;
  assign bus.dcache_rdata = dcache_rdata_r;
  assign bus.icache_resp  = icache_resp_r;
  assign bus.dcache_resp  = dcache_resp_r;
  assign bus.busy         = busy_r;

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      starve_cnt_r   <= ZERO_C;
      addr_r         <= 16'h0000;
      wdata_r        <= 128'd0;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
      icache_rdata_r <= 128'd0;
      dcache_rdata_r <= 128'd0;
      icache_resp_r  <= 1'b0;
      dcache_resp_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          icache_resp_r <= 1'b0;
          dcache_resp_r <= 1'b0;
          if (dgrant_s) begin
            // Latch the dcache request; the op decides the memory strobe.
            addr_r      <= bus.dcache_address;
            wdata_r     <= bus.dcache_wdata;
            mem_write_r <= bus.dcache_write;
            mem_read_r  <= ~bus.dcache_write;
            busy_r      <= 1'b1;
            state_r     <= SERVE_D;
            if (ipend_s) begin
              if (starve_cnt_r < LIMIT_C) begin
                starve_cnt_r <= starve_cnt_r + ONE_C;
              end else begin
                starve_cnt_r <= starve_cnt_r;
              end
            end else begin
              starve_cnt_r <= ZERO_C;
            end
          end else if (ipend_s) begin
            // Line fill is always a read; stale wdata is never used.
            addr_r       <= bus.icache_address;
            mem_read_r   <= 1'b1;
            mem_write_r  <= 1'b0;
            starve_cnt_r <= ZERO_C;
            busy_r       <= 1'b1;
            state_r      <= SERVE_I;
          end else begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end

        SERVE_I: begin
          if (bus.mem_resp) begin
            icache_rdata_r <= bus.mem_rdata;
            icache_resp_r  <= 1'b1;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            state_r        <= RESP_I;
          end else begin
            state_r <= SERVE_I;
          end
        end

        SERVE_D: begin
          if (bus.mem_resp) begin
            // A write completion leaves the last read line untouched.
            if (!mem_write_r) begin
              dcache_rdata_r <= bus.mem_rdata;
            end else begin
              dcache_rdata_r <= dcache_rdata_r;
            end
            dcache_resp_r <= 1'b1;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            state_r       <= RESP_D;
          end else begin
            state_r <= SERVE_D;
          end
        end

        RESP_I: begin
          icache_resp_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end

        RESP_D: begin
          dcache_resp_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet idle.
          mem_read_r    <= 1'b0;
          mem_write_r   <= 1'b0;
          icache_resp_r <= 1'b0;
          dcache_resp_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single grants, dcache priority, starvation
// limit, address stability, asynchronous reset and stray responses.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   miss_cnt;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ngrant;
    logic done;

    vec_cnt  = 0;
    miss_cnt = 0;
    reset = 1'b1;
    bus.icache_read    = 1'b0;
    bus.icache_address = 16'h0000;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = 16'h0000;
    bus.dcache_wdata   = 128'd0;
    bus.mem_rdata      = 128'd0;
    bus.mem_resp       = 1'b0;
    #1;
    chk_vec("rst_busy",     128'(bus.busy),         128'd0);
    chk_vec("rst_mem_read", 128'(bus.mem_read),     128'd0);
    chk_vec("rst_mem_addr", 128'(bus.mem_address),  128'd0);
    chk_vec("rst_irdata",   bus.icache_rdata,       128'd0);
    tick();
    reset = 1'b0;

    // Single icache fill: request cycle 0, mem_resp cycle 4, resp cycle 5.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h1230;
    tick();
    chk_vec("i_c1_mem_read",  128'(bus.mem_read),    128'd1);
    chk_vec("i_c1_mem_write", 128'(bus.mem_write),   128'd0);
    chk_vec("i_c1_addr",      128'(bus.mem_address), 128'h1230);
    chk_vec("i_c1_busy",      128'(bus.busy),        128'd1);
    tick();
    tick();
    tick();
    chk_vec("i_c4_mem_read",  128'(bus.mem_read),    128'd1);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'hAAAA}};
    tick();
    bus.mem_resp  = 1'b0;
    chk_vec("i_c5_resp",     128'(bus.icache_resp), 128'd1);
    chk_vec("i_c5_rdata",    bus.icache_rdata,      {8{16'hAAAA}});
    chk_vec("i_c5_mem_read", 128'(bus.mem_read),    128'd0);
    chk_vec("i_c5_dresp",    128'(bus.dcache_resp), 128'd0);
    bus.icache_read = 1'b0;
    tick();
    chk_vec("i_c6_resp", 128'(bus.icache_resp), 128'd0);
    chk_vec("i_c6_busy", 128'(bus.busy),        128'd0);

    // Simultaneous icache read and dcache write: dcache first.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h2220;
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 16'h4000;
    bus.dcache_wdata   = {8{16'h5555}};
    tick();
    chk_vec("dw_mem_write", 128'(bus.mem_write),   128'd1);
    chk_vec("dw_mem_read",  128'(bus.mem_read),    128'd0);
    chk_vec("dw_addr",      128'(bus.mem_address), 128'h4000);
    chk_vec("dw_wdata",     bus.mem_wdata,         {8{16'h5555}});
    chk_vec("dw_starve",    128'(dut.starve_cnt_r), 128'd1);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'h1111}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("dw_dresp",  128'(bus.dcache_resp), 128'd1);
    chk_vec("dw_iresp",  128'(bus.icache_resp), 128'd0);
    chk_vec("dw_drdata", bus.dcache_rdata,      128'd0);
    bus.dcache_write = 1'b0;
    tick();
    chk_vec("dw_idle_busy", 128'(bus.busy), 128'd0);
    tick();
    chk_vec("dw_i_read", 128'(bus.mem_read),    128'd1);
    chk_vec("dw_i_addr", 128'(bus.mem_address), 128'h2220);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'h3333}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("dw_i_resp",  128'(bus.icache_resp), 128'd1);
    chk_vec("dw_i_rdata", bus.icache_rdata,      {8{16'h3333}});
    chk_vec("dw_i_starve", 128'(dut.starve_cnt_r), 128'd0);
    bus.icache_read = 1'b0;
    tick();

    // Starvation: icache held, dcache re-requesting continuously.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h7770;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h5000;
    ngrant = 0;
    done   = 1'b0;
    for (int g = 0; g < 8 && !done; g++) begin
      tick();
      if (bus.mem_read && bus.mem_address == 16'h5000) begin
        ngrant++;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = {16{8'(g + 1)}};
        tick();
        bus.mem_resp = 1'b0;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk_vec("st_dgrants",  128'(ngrant),             128'd4);
    chk_vec("st_i_addr",   128'(bus.mem_address),    128'h7770);
    chk_vec("st_i_read",   128'(bus.mem_read),       128'd1);
    chk_vec("st_cnt_zero", 128'(dut.starve_cnt_r),   128'd0);
    chk_vec("st_drdata",   bus.dcache_rdata,         {16{8'h04}});
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'hC0DE}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("st_i_resp", 128'(bus.icache_resp), 128'd1);
    bus.icache_read = 1'b0;
    tick();
    tick();
    chk_vec("st_d_again",  128'(bus.mem_address),  128'h5000);
    chk_vec("st_cnt_alone", 128'(dut.starve_cnt_r), 128'd0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'hBEEF}};
    tick();
    bus.mem_resp    = 1'b0;
    bus.dcache_read = 1'b0;
    tick();

    // Address change during SERVE_D must not reach the memory port.
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h4000;
    tick();
    chk_vec("ad_first", 128'(bus.mem_address), 128'h4000);
    bus.dcache_address = 16'h6000;
    tick();
    chk_vec("ad_held", 128'(bus.mem_address), 128'h4000);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'h9999}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("ad_resp_addr", 128'(bus.mem_address), 128'h4000);
    chk_vec("ad_dresp",     128'(bus.dcache_resp), 128'd1);
    chk_vec("ad_drdata",    bus.dcache_rdata,      {8{16'h9999}});
    bus.dcache_read = 1'b0;
    tick();

    // Asynchronous reset mid SERVE_I, then a stray mem_resp.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h1230;
    tick();
    chk_vec("rs_serving", 128'(bus.mem_read), 128'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_vec("rs_mem_read", 128'(bus.mem_read),    128'd0);
    chk_vec("rs_busy",     128'(bus.busy),        128'd0);
    chk_vec("rs_addr",     128'(bus.mem_address), 128'd0);
    chk_vec("rs_irdata",   bus.icache_rdata,      128'd0);
    chk_vec("rs_drdata",   bus.dcache_rdata,      128'd0);
    bus.icache_read = 1'b0;
    tick();
    reset         = 1'b0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'hFFFF}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("rs_stray_iresp", 128'(bus.icache_resp), 128'd0);
    chk_vec("rs_stray_busy",  128'(bus.busy),        128'd0);
    chk_vec("rs_stray_rdata", bus.icache_rdata,      128'd0);

    // Stray mem_resp in IDLE with nothing pending.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{16'h7E7E}};
    tick();
    bus.mem_resp = 1'b0;
    chk_vec("id_iresp", 128'(bus.icache_resp), 128'd0);
    chk_vec("id_dresp", 128'(bus.dcache_resp), 128'd0);
    chk_vec("id_busy",  128'(bus.busy),        128'd0);
    tick();
    chk_vec("id_busy2", 128'(bus.busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
